// File: rtl/ipml_prefetch_fifo_v2_0.sv
// ---------------------------------------------------------------------------
// ipml_prefetch_fifo_v2_0
//
// Single-clock FIFO built from an inferred simple dual-port RAM (registered
// read) followed by a small register prefetch buffer. The buffer gives a
// first-word fall-through read port that can pop one word every cycle.
//
// Ports
//   rd_clk        : clock for both the write and read sides
//   rd_rst        : asynchronous active-high reset
//   flush         : synchronous clear of all pointers, counters and flags
//   wr_data/wr_en : write data / write request
//   wr_vld        : write ready (write accepted when wr_en && wr_vld)
//   rd_data       : head-of-FIFO word, valid while rd_vld is high
//   rd_vld        : rd_data valid
//   rd_en         : read request (pop when rd_en && rd_vld)
//   level         : total stored words (RAM + in-flight read + buffer)
//   almost_full   : level >= AF_LEVEL (registered)
//   almost_empty  : level <= AE_LEVEL (registered)
//   ovf_err       : sticky, write attempted while not ready
//   udf_err       : sticky, read attempted while not valid
// ---------------------------------------------------------------------------
module ipml_prefetch_fifo_v2_0 #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int PF_DEPTH = 2,
    parameter int AF_LEVEL = (2**ADDR_W) - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              wr_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    input  logic              rd_en,
    output logic [ADDR_W+1:0] level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int LW    = ADDR_W + 2;

    // RAM and its registered read port
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q_reg;

    // Control state
    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [ADDR_W:0]   ram_cnt_reg;
    logic [ADDR_W:0]   ram_cnt_next;
    logic              inflight_reg;
    logic [2:0]        pf_cnt_reg;
    logic [2:0]        pf_cnt_next;
    logic [LW-1:0]     level_reg;
    logic [LW-1:0]     level_next;
    logic              af_reg;
    logic              ae_reg;
    logic              ovf_reg;
    logic              udf_reg;
    // Low for the first cycle after reset release so wr_vld rises on the
    // first edge rather than combinationally with the reset deassertion.
    logic              run_reg;

    // Prefetch buffer: entry 0 is the head, entries shift down on a pop.
    logic [PF_DEPTH-1:0][DATA_W-1:0] pf_data_reg;
    logic [PF_DEPTH-1:0][DATA_W-1:0] pf_data_next;

    logic       push;
    logic       pop;
    logic       rd_issue;
    logic       pf_load;
    logic [3:0] pf_demand;
    logic [2:0] load_idx;

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    // ram_cnt never exceeds DEPTH, so its MSB alone marks a full RAM.
    assign wr_vld = run_reg && !ram_cnt_reg[ADDR_W] && !flush;
    assign rd_vld = (pf_cnt_reg != 3'd0);
    assign push   = wr_en && wr_vld;
    assign pop    = rd_en && rd_vld && !flush;

    // Buffer slots already spoken for after this cycle's pop; a new RAM read
    // may only be launched if its word is guaranteed a free slot on arrival.
    assign pf_demand = {1'b0, pf_cnt_reg} + {3'b000, inflight_reg} - {3'b000, pop};
    assign rd_issue  = !flush && (ram_cnt_reg != '0) && (pf_demand < 4'(PF_DEPTH));

    // Returning read data is dropped during a flush.
    assign pf_load  = inflight_reg && !flush;
    // Arriving word lands just above the surviving entries.
    assign load_idx = pop ? (pf_cnt_reg - 3'd1) : pf_cnt_reg;

    // -----------------------------------------------------------------------
    // Next-state counters
    // -----------------------------------------------------------------------
    always_comb begin
        ram_cnt_next = ram_cnt_reg + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, rd_issue};
        pf_cnt_next  = pf_cnt_reg + {2'b00, pf_load} - {2'b00, pop};
        // A read issued this cycle is counted as in flight after the edge.
        level_next   = LW'(ram_cnt_next) + {{(LW-1){1'b0}}, rd_issue} + LW'(pf_cnt_next);
        if (flush) begin
            ram_cnt_next = '0;
            pf_cnt_next  = '0;
            level_next   = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
            pf_cnt_reg   <= '0;
            level_reg    <= '0;
            af_reg       <= (AF_LEVEL <= 0);
            ae_reg       <= 1'b1;
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
            run_reg      <= 1'b0;
        end else begin
            run_reg      <= 1'b1;
            ram_cnt_reg  <= ram_cnt_next;
            pf_cnt_reg   <= pf_cnt_next;
            level_reg    <= level_next;
            inflight_reg <= rd_issue;
            af_reg       <= (int'(level_next) >= AF_LEVEL);
            ae_reg       <= (int'(level_next) <= AE_LEVEL);
            if (flush) begin
                wptr_reg <= '0;
                rptr_reg <= '0;
                ovf_reg  <= 1'b0;
                udf_reg  <= 1'b0;
            end else begin
                if (push) begin
                    wptr_reg <= wptr_reg + 1'b1;
                end
                if (rd_issue) begin
                    rptr_reg <= rptr_reg + 1'b1;
                end
                if (wr_en && !wr_vld) begin
                    ovf_reg <= 1'b1;
                end
                if (rd_en && !rd_vld) begin
                    udf_reg <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage RAM (contents are never reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (push) begin
            mem[wptr_reg] <= wr_data;
        end
        if (rd_issue) begin
            ram_q_reg <= mem[rptr_reg];
        end
    end

    // -----------------------------------------------------------------------
    // Prefetch buffer entries
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < PF_DEPTH; gi++) begin : g_pf
            logic [DATA_W-1:0] shift_src;
            if (gi < PF_DEPTH - 1) begin : g_mid
                assign shift_src = pf_data_reg[gi+1];
            end else begin : g_top
                assign shift_src = pf_data_reg[gi];
            end
            assign pf_data_next[gi] = (pf_load && (load_idx == 3'(gi))) ? ram_q_reg :
                                      pop                              ? shift_src :
                                                                         pf_data_reg[gi];
        end
    endgenerate

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            pf_data_reg <= '0;
        end else begin
            pf_data_reg <= pf_data_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rd_data      = pf_data_reg[0];
    assign level        = level_reg;
    assign almost_full  = af_reg;
    assign almost_empty = ae_reg;
    assign ovf_err      = ovf_reg;
    assign udf_err      = udf_reg;

endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0.sv
// ---------------------------------------------------------------------------
// tb_ipml_prefetch_fifo_v2_0
//
// Scoreboard bench for ipml_prefetch_fifo_v2_0 (ADDR_W=4, PF_DEPTH=2).
// The driver pushes every accepted write into exp_q; an independent monitor
// on the falling edge pops exp_q on every pop handshake and keeps a word
// count / sticky-flag model that the DUT outputs are held against each cycle.
// ---------------------------------------------------------------------------
module tb_ipml_prefetch_fifo_v2_0;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int PD    = 2;
    localparam int DEPTH = 16;
    localparam int CAP   = DEPTH + PD;
    localparam int AFL   = DEPTH - 4;
    localparam int AEL   = 4;

    logic          clk     = 1'b0;
    logic          rd_rst  = 1'b1;
    logic          flush   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic          wr_vld;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic [AW+1:0] level;
    logic          almost_full;
    logic          almost_empty;
    logic          ovf_err;
    logic          udf_err;

    ipml_prefetch_fifo_v2_0 #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .PF_DEPTH(PD),
        .AF_LEVEL(AFL),
        .AE_LEVEL(AEL)
    ) dut (
        .rd_clk      (clk),
        .rd_rst      (rd_rst),
        .flush       (flush),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_vld      (wr_vld),
        .rd_data     (rd_data),
        .rd_vld      (rd_vld),
        .rd_en       (rd_en),
        .level       (level),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q [$];

    // Reference model state (owned by the monitor)
    int            model_cnt = 0;
    bit            m_ovf     = 1'b0;
    bit            m_udf     = 1'b0;
    int            rst_age   = 0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            n_pops    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        @(posedge clk);
        #1;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        #1;
        if (f) begin
            exp_q.delete();
        end else if (w && wr_vld) begin
            exp_q.push_back(d);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (rd_rst) begin
            chk("rst_rd_vld", rd_vld, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_level", level, 0);
            chk("rst_wr_vld", wr_vld, 0);
            chk("rst_almost_full", almost_full, 0);
            chk("rst_almost_empty", almost_empty, 1);
            chk("rst_ovf", ovf_err, 0);
            chk("rst_udf", udf_err, 0);
            model_cnt = 0;
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
            rst_age   = 0;
            hold_prev = 1'b0;
        end else begin
            chk("level", level, model_cnt);
            chk("almost_full", almost_full, longint'(model_cnt >= AFL));
            chk("almost_empty", almost_empty, longint'(model_cnt <= AEL));
            chk("ovf_err", ovf_err, longint'(m_ovf));
            chk("udf_err", udf_err, longint'(m_udf));
            if (model_cnt == 0) begin
                chk("rd_vld_empty", rd_vld, 0);
            end
            if (rst_age == 0) begin
                chk("wr_vld_after_rst", wr_vld, 0);
            end else if (flush) begin
                chk("wr_vld_flush", wr_vld, 0);
            end else if (model_cnt < DEPTH) begin
                chk("wr_vld_room", wr_vld, 1);
            end else if (model_cnt == CAP) begin
                chk("wr_vld_full", wr_vld, 0);
            end
            if (hold_prev) begin
                chk("hold_rd_vld", rd_vld, 1);
                chk("hold_rd_data", rd_data, prev_data);
            end

            hold_prev = rd_vld && !rd_en && !flush;
            prev_data = rd_data;
            if (flush) begin
                model_cnt = 0;
                m_ovf     = 1'b0;
                m_udf     = 1'b0;
            end else begin
                if (wr_en && wr_vld) begin
                    model_cnt++;
                end else if (wr_en) begin
                    m_ovf = 1'b1;
                end
                if (rd_en && rd_vld) begin
                    n_pops++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL pop_order: got %0h expected no data (t=%0t)", rd_data, $time);
                    end else begin
                        chk("pop_data", rd_data, exp_q.pop_front());
                    end
                    model_cnt--;
                end else if (rd_en) begin
                    m_udf = 1'b1;
                end
            end
            rst_age++;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rd_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rd_rst = 1'b0;
        step(0, '0, 0, 0);
        chk("wr_vld_rise", wr_vld, 1);

        // Single word latency and pop
        step(1, 32'hA5A5A5A5, 0, 0);
        step(0, '0, 0, 0);
        chk("lat_k", rd_vld, 0);
        step(0, '0, 0, 0);
        chk("lat_k1", rd_vld, 0);
        step(0, '0, 0, 0);
        chk("lat_k2_vld", rd_vld, 1);
        chk("lat_k2_data", rd_data, 32'hA5A5A5A5);
        chk("lat_k2_level", level, 1);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        chk("pop_rd_vld", rd_vld, 0);
        chk("pop_level", level, 0);

        // Fill to capacity, then overflow
        for (int i = 0; i < 20; i++) step(1, $urandom, 0, 0);
        step(0, '0, 0, 0);
        chk("full_wr_vld", wr_vld, 0);
        chk("full_level", level, CAP);
        chk("full_af", almost_full, 1);
        step(1, $urandom, 0, 0);
        step(1, $urandom, 0, 0);
        step(0, '0, 0, 0);
        chk("ovf_set", ovf_err, 1);
        chk("ovf_level", level, CAP);
        for (int i = 0; i < 20; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        chk("flush_ovf", ovf_err, 0);
        chk("flush_level", level, 0);

        // Streaming: one write and one read every cycle
        for (int i = 0; i < 1000; i++) begin
            step(1, DW'(i) ^ 32'h5A000000, 1, 0);
            if (i >= 3) chk("stream_rd_vld", rd_vld, 1);
            chk("stream_level_le3", longint'(level <= 3), 1);
        end
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 1);

        // Flush while a RAM read is in flight
        for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 0, 0);
        chk("pre_flush_level8", level, 8);
        step(0, '0, 1, 0);
        step(0, '0, 0, 1);
        chk("pre_flush_level7", level, 7);
        step(0, '0, 0, 0);
        chk("post_flush_level", level, 0);
        chk("post_flush_rd_vld", rd_vld, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 0, 0);
            chk("post_flush_quiet", rd_vld, 0);
        end
        for (int i = 0; i < 3; i++) step(1, 32'hC0DE0000 | DW'(i), 0, 0);
        for (int i = 0; i < 6; i++) step(0, '0, 1, 0);

        // Underflow on an empty FIFO
        step(0, '0, 0, 1);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        chk("udf_set", udf_err, 1);
        chk("udf_level", level, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) step(1, $urandom, 1, 0);
        @(posedge clk);
        #3;
        rd_rst = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_rd_vld", rd_vld, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_level", level, 0);
        chk("arst_wr_vld", wr_vld, 0);
        chk("arst_ae", almost_empty, 1);
        chk("arst_udf", udf_err, 0);
        @(posedge clk);
        #1 rd_rst = 1'b0;
        step(0, '0, 0, 0);
        chk("arst_wr_vld_rise", wr_vld, 1);

        // Random traffic with occasional flush
        for (int i = 0; i < 20000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 999) == 0));
        end
        for (int i = 0; i < 25; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        chk("final_level", level, 0);
        chk("final_queue", exp_q.size(), 0);
        chk("pops_seen", longint'(n_pops > 5000), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
